// File: rtl/ws2812_pkg.sv
// Shared definitions for the MMIO WS2812 streamer.
// Holds the register map offsets, CTRL/STATUS bit positions, the streaming FSM
// state encoding and a small count-saturation helper.
package ws2812_pkg;

  // Byte offsets within the MMIO window.
  localparam logic [31:0] OffPixel  = 32'h0;
  localparam logic [31:0] OffCtrl   = 32'h4;
  localparam logic [31:0] OffStatus = 32'h8;
  localparam logic [31:0] WindowBytes = 32'd12;

  // CTRL write bits.
  localparam int unsigned CtrlLatchBit  = 0;
  localparam int unsigned CtrlClrOvfBit = 1;

  // STATUS read bits.
  localparam int unsigned StatEmptyBit = 0;
  localparam int unsigned StatFullBit  = 1;
  localparam int unsigned StatBusyBit  = 2;
  localparam int unsigned StatOvfBit   = 3;
  localparam int unsigned StatCountLsb = 4;

  localparam int unsigned PixelBits = 24;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StHigh  = 3'd2,
    StLow   = 3'd3,
    StLatch = 3'd4
  } ws_state_e;

  // The STATUS count field is only four bits wide.
  function automatic logic [3:0] sat_count4(input logic [31:0] count);
    return (count > 32'd15) ? 4'hF : count[3:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with asynchronous active-high reset.
// Ports:
//   clk_i, rst_i     clock, async active-high reset
//   push_i, wdata_i  write request and data (accepted when not full, or when
//                    a pop happens in the same cycle)
//   pop_i, rdata_o   pop request and head-of-queue data (show-ahead)
//   full_o, empty_o  occupancy flags
//   count_o          number of stored entries
module sync_fifo #(
  parameter int unsigned Width = 24,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_i && (!full_o || do_pop);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mmio_ws2812_streamer.sv
// Memory-mapped WS2812 LED streamer.
// A 3-word MMIO window (PIXEL, CTRL, STATUS) feeds 24-bit GRB pixels into a
// FIFO; an FSM serialises them MSB first as WS2812 high/low pulses and, on
// request, holds the line low for the latch gap once the FIFO has drained.
// Ports:
//   clock, reset   system clock, async active-high reset
//   wren           store enable from the processor
//   address_dmem   store/load address
//   data           store data
//   q_mmio         STATUS word when address_dmem is BASE+8, else 0
//   mmio_sel       address_dmem falls inside the 3-word window
//   led_dout       WS2812 serial line (registered)
//   busy           streaming, data queued, or a latch still pending
module mmio_ws2812_streamer
  import ws2812_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_F000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned T0H        = 20,
  parameter int unsigned T1H        = 40,
  parameter int unsigned TBIT       = 62,
  parameter int unsigned TLATCH     = 3000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wren,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  output logic [31:0] q_mmio,
  output logic        mmio_sel,
  output logic        led_dout,
  output logic        busy
);

  localparam int unsigned CntMax   = (TBIT > TLATCH) ? TBIT : TLATCH;
  localparam int unsigned CntW     = $clog2(CntMax + 1);
  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CntW-1:0] T0hLast    = CntW'(T0H - 1);
  localparam logic [CntW-1:0] T1hLast    = CntW'(T1H - 1);
  localparam logic [CntW-1:0] TbitLast   = CntW'(TBIT - 1);
  localparam logic [CntW-1:0] TlatchLast = CntW'(TLATCH - 1);

  // Address decode
  logic [31:0] addr_off;
  logic        wr_pixel, wr_ctrl, rd_status;

  assign addr_off  = address_dmem - BASE_ADDR;
  assign mmio_sel  = (address_dmem >= BASE_ADDR) && (addr_off < WindowBytes);
  assign wr_pixel  = wren && mmio_sel && (addr_off == OffPixel);
  assign wr_ctrl   = wren && mmio_sel && (addr_off == OffCtrl);
  assign rd_status = mmio_sel && (addr_off == OffStatus);

  logic unused_data;
  assign unused_data = ^data[31:PixelBits];

  // Pixel FIFO
  logic [PixelBits-1:0] fifo_rdata;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [FifoCntW-1:0]  fifo_count;

  sync_fifo #(
    .Width(PixelBits),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clock),
    .rst_i  (reset),
    .push_i (wr_pixel),
    .wdata_i(data[PixelBits-1:0]),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  // Streaming FSM state
  ws_state_e            state_q;
  logic [CntW-1:0]      cnt_q;
  logic [4:0]           bit_idx_q;
  logic [PixelBits-1:0] shift_q;
  logic                 led_q;
  logic                 latch_pending_q, latch_pending_d;
  logic                 overflow_q, overflow_d;
  logic [CntW-1:0]      high_last;
  logic                 latch_done;

  assign fifo_pop   = (state_q == StLoad);
  assign high_last  = shift_q[PixelBits-1] ? T1hLast : T0hLast;
  assign latch_done = (state_q == StLatch) && (cnt_q == TlatchLast);

  // cnt_q runs from HIGH entry through LOW so every bit is exactly TBIT cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      led_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          led_q <= 1'b0;
          cnt_q <= '0;
          if (!fifo_empty)          state_q <= StLoad;
          else if (latch_pending_q) state_q <= StLatch;
        end
        StLoad: begin
          shift_q   <= fifo_rdata;
          bit_idx_q <= 5'(PixelBits - 1);
          cnt_q     <= '0;
          led_q     <= 1'b1;
          state_q   <= StHigh;
        end
        StHigh: begin
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == high_last) begin
            led_q   <= 1'b0;
            state_q <= StLow;
          end
        end
        StLow: begin
          if (cnt_q == TbitLast) begin
            cnt_q <= '0;
            if (bit_idx_q == '0) begin
              state_q <= fifo_empty ? StIdle : StLoad;
            end else begin
              bit_idx_q <= bit_idx_q - 5'd1;
              shift_q   <= shift_q << 1;
              led_q     <= 1'b1;
              state_q   <= StHigh;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StLatch: begin
          led_q <= 1'b0;
          if (latch_done) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          led_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Sticky flags. A set in the same cycle as a clear wins in both cases, so a
  // request or drop is never lost.
  always_comb begin
    latch_pending_d = latch_pending_q;
    if (latch_done) latch_pending_d = 1'b0;
    if (wr_ctrl && data[CtrlLatchBit]) latch_pending_d = 1'b1;

    overflow_d = overflow_q;
    if (wr_ctrl && data[CtrlClrOvfBit]) overflow_d = 1'b0;
    if (wr_pixel && fifo_full && !fifo_pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      latch_pending_q <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      latch_pending_q <= latch_pending_d;
      overflow_q      <= overflow_d;
    end
  end

  // A pending latch keeps busy high across the single IDLE cycle between the
  // last bit and LATCH, so busy only falls when the latch gap completes.
  assign busy     = (state_q != StIdle) || !fifo_empty || latch_pending_q;
  assign led_dout = led_q;

  logic [31:0] status_word;
  always_comb begin
    status_word = '0;
    status_word[StatEmptyBit] = fifo_empty;
    status_word[StatFullBit]  = fifo_full;
    status_word[StatBusyBit]  = busy;
    status_word[StatOvfBit]   = overflow_q;
    status_word[StatCountLsb +: 4] = sat_count4(32'(fifo_count));
  end

  assign q_mmio = rd_status ? status_word : 32'h0;

endmodule

// File: tb/tb_mmio_ws2812_streamer.sv
// Directed self-checking bench for mmio_ws2812_streamer.
module tb_mmio_ws2812_streamer;

  localparam logic [31:0] Base = 32'hFFFF_F000;

  logic        clock = 1'b0;
  logic        reset;
  logic        wren;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic [31:0] q_mmio;
  logic        mmio_sel;
  logic        led_dout;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mmio_ws2812_streamer dut (
    .clock       (clock),
    .reset       (reset),
    .wren        (wren),
    .address_dmem(address_dmem),
    .data        (data),
    .q_mmio      (q_mmio),
    .mmio_sel    (mmio_sel),
    .led_dout    (led_dout),
    .busy        (busy)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Presents one store for the next rising edge; returns at the following negedge.
  task automatic write(input logic [31:0] addr, input logic [31:0] d);
    wren = 1'b1;
    address_dmem = addr;
    data = d;
    @(negedge clock);
    wren = 1'b0;
    address_dmem = 32'h0;
    data = 32'h0;
  endtask

  task automatic read_status(input string tag, input logic [31:0] exp);
    address_dmem = Base + 32'h8;
    #1;
    check32(tag, q_mmio, exp);
    address_dmem = 32'h0;
  endtask

  // Expected line level k samples after the PIXEL write edge (first rise at k=2).
  function automatic logic exp_led(input int k, input logic [23:0] pix);
    int t, b, w;
    if (k < 2) return 1'b0;
    t = k - 2;
    b = t / 62;
    w = t % 62;
    if (b >= 24) return 1'b0;
    return (w < (pix[23 - b] ? 40 : 20));
  endfunction

  logic [23:0] pix;
  logic        prev_led;
  int          rises;
  int          waited;

  initial begin
    reset = 1'b1;
    wren = 1'b0;
    address_dmem = 32'h0;
    data = 32'h0;
    repeat (3) @(negedge clock);
    check1("reset_led", led_dout, 1'b0);
    check1("reset_busy", busy, 1'b0);
    read_status("reset_status", 32'h01);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Stores outside the register set are ignored.
    write(Base + 32'hC, 32'h0012_3456);
    write(32'h0000_0010, 32'h00AB_CDEF);
    address_dmem = 32'h0000_0010;
    #1;
    check1("ram_sel", mmio_sel, 1'b0);
    check32("ram_q", q_mmio, 32'h0);
    address_dmem = Base + 32'hC;
    #1;
    check1("base12_sel", mmio_sel, 1'b0);
    address_dmem = Base + 32'h4;
    #1;
    check1("ctrl_sel", mmio_sel, 1'b1);
    check32("ctrl_q", q_mmio, 32'h0);
    address_dmem = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check1("stray_led", led_dout, 1'b0);
      check1("stray_busy", busy, 1'b0);
    end
    read_status("stray_status", 32'h01);

    // Single pixel waveform, cycle by cycle.
    @(negedge clock);
    pix = 24'hA50000;
    write(Base, {8'h0, pix});
    for (int k = 0; k <= 1495; k++) begin
      check1($sformatf("wave_led k=%0d", k), led_dout, exp_led(k, pix));
      check1($sformatf("wave_busy k=%0d", k), busy, (k < 1490));
      @(negedge clock);
    end
    read_status("wave_done_status", 32'h01);

    // Occupancy, overflow and overflow clear while a pixel is streaming.
    write(Base, 32'h00FF_FFFF);
    repeat (2) @(negedge clock);
    read_status("loaded_status", 32'h05);
    for (int i = 0; i < 3; i++) write(Base, 32'h0000_0100 + 32'(i));
    read_status("three_status", 32'h34);
    for (int i = 0; i < 6; i++) write(Base, 32'h0000_0200 + 32'(i));
    read_status("ovf_status", 32'h8E);
    write(Base + 32'h4, 32'h2);
    read_status("ovf_clr_status", 32'h86);
    waited = 0;
    while (busy && waited < 20000) begin
      @(negedge clock);
      waited++;
    end
    check1("drain_busy", busy, 1'b0);
    read_status("drain_status", 32'h01);

    // Two pixels then a latch request.
    @(negedge clock);
    write(Base, 32'h0000_0001);
    write(Base, 32'h0080_0000);
    write(Base + 32'h4, 32'h1);
    prev_led = 1'b0;
    rises = 0;
    for (int k = 2; k <= 5985; k++) begin
      if (led_dout && !prev_led) rises++;
      prev_led = led_dout;
      check1($sformatf("latch_busy k=%0d", k), busy, (k < 5980));
      if (k >= 2979) check1($sformatf("latch_low k=%0d", k), led_dout, 1'b0);
      @(negedge clock);
    end
    check32("latch_rises", 32'(rises), 32'd48);
    read_status("latch_status", 32'h01);

    // Reset in the middle of bit 10.
    write(Base, 32'h00FF_FFFF);
    repeat (627) @(negedge clock);
    check1("bit10_high", led_dout, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check1("abort_led", led_dout, 1'b0);
    check1("abort_busy", busy, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    read_status("abort_status", 32'h01);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      check1("abort_quiet", led_dout, 1'b0);
    end
    read_status("abort_final_status", 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
